// File: rtl/multi_zone_temp_controller.sv
// Multi-zone heat/cool thermostat: one IDLE/HEAT/COOL/FAULT FSM per zone with hysteresis,
// minimum actuator on-time and a run-time timeout that latches the zone in FAULT.
module multi_zone_temp_controller #(
   parameter int unsigned TW      = 7,
   parameter int unsigned ZONES   = 2,
   parameter int unsigned MIN_ON  = 4,
   parameter int unsigned TIMEOUT = 20,
   parameter int unsigned CW      = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ZONES-1:0]      en,
   input  logic [ZONES*TW-1:0]   troom,
   input  logic [ZONES*TW-1:0]   tref,
   input  logic [TW-1:0]         dt,
   input  logic                  fault_clr,
   output logic [ZONES-1:0]      h,
   output logic [ZONES-1:0]      c,
   output logic [ZONES-1:0]      fault,
   output logic                  busy
);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StHeat  = 2'd1;
   localparam logic [1:0] StCool  = 2'd2;
   localparam logic [1:0] StFault = 2'd3;

   localparam logic [CW-1:0] CntMax   = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] CntMinOn = CW'(MIN_ON - 1);

   logic [TW:0] dt_x;

   assign dt_x = {1'b0, dt};

   for (genvar i = 0; i < ZONES; i++) begin : g_zone
      logic [1:0]    state_q, state_d;
      logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
      logic          h_q, c_q, fault_q;
      logic [TW:0]   troom_x, tref_x, lo, hi;
      logic          below_lo, above_hi, at_or_above_ref, at_or_below_ref;

      // One extra bit keeps tref+dt from wrapping; lo saturates at zero.
      assign troom_x = {1'b0, troom[i*TW +: TW]};
      assign tref_x  = {1'b0, tref[i*TW +: TW]};
      assign lo      = (tref_x >= dt_x) ? (tref_x - dt_x) : '0;
      assign hi      = tref_x + dt_x;

      assign below_lo        = troom_x < lo;
      assign above_hi        = troom_x > hi;
      assign at_or_above_ref = troom_x >= tref_x;
      assign at_or_below_ref = troom_x <= tref_x;
      assign cnt_inc         = (cnt_q == CntMax) ? cnt_q : cnt_q + CW'(1);

      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         case (state_q)
            StIdle: begin
               cnt_d = '0;
               if (start && en[i] && below_lo) begin
                  state_d = StHeat;
               end else if (start && en[i] && above_hi) begin
                  state_d = StCool;
               end
            end
            StHeat: begin
               cnt_d = cnt_inc;
               // Enable drop is the safety cut and overrides the minimum on-time.
               if (!en[i]) begin
                  state_d = StIdle;
                  cnt_d   = '0;
               end else if (at_or_above_ref && (cnt_q >= CntMinOn)) begin
                  state_d = StIdle;
                  cnt_d   = '0;
               end else if ((cnt_q == CntMax) && !at_or_above_ref) begin
                  state_d = StFault;
                  cnt_d   = '0;
               end
            end
            StCool: begin
               cnt_d = cnt_inc;
               if (!en[i]) begin
                  state_d = StIdle;
                  cnt_d   = '0;
               end else if (at_or_below_ref && (cnt_q >= CntMinOn)) begin
                  state_d = StIdle;
                  cnt_d   = '0;
               end else if ((cnt_q == CntMax) && !at_or_below_ref) begin
                  state_d = StFault;
                  cnt_d   = '0;
               end
            end
            StFault: begin
               cnt_d = '0;
               if (fault_clr) begin
                  state_d = StIdle;
               end
            end
            default: begin
               state_d = StIdle;
               cnt_d   = '0;
            end
         endcase
      end

      // Outputs are decoded from the next state so they align with the state register.
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            h_q     <= 1'b0;
            c_q     <= 1'b0;
            fault_q <= 1'b0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            h_q     <= (state_d == StHeat);
            c_q     <= (state_d == StCool);
            fault_q <= (state_d == StFault);
         end
      end

      assign h[i]     = h_q;
      assign c[i]     = c_q;
      assign fault[i] = fault_q;
   end

   assign busy = |{h, c};

endmodule

// File: tb/tb_multi_zone_temp_controller.sv
// Directed bench for multi_zone_temp_controller (TW=7, ZONES=2, MIN_ON=4, TIMEOUT=20).
module tb_multi_zone_temp_controller;

   logic        clk;
   logic        reset;
   logic        start;
   logic [1:0]  en;
   logic [6:0]  tr0, tr1, rf0, rf1;
   logic [13:0] troom, tref;
   logic [6:0]  dt;
   logic        fault_clr;
   logic [1:0]  h, c, fault;
   logic        busy;

   int errors = 0;
   int checks = 0;

   assign troom = {tr1, tr0};
   assign tref  = {rf1, rf0};

   multi_zone_temp_controller #(
      .TW      (7),
      .ZONES   (2),
      .MIN_ON  (4),
      .TIMEOUT (20),
      .CW      (8)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .en        (en),
      .troom     (troom),
      .tref      (tref),
      .dt        (dt),
      .fault_clr (fault_clr),
      .h         (h),
      .c         (c),
      .fault     (fault),
      .busy      (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [6:0] ev(input logic [1:0] eh, input logic [1:0] ec,
                                     input logic [1:0] ef);
      return {eh, ec, ef, |{eh, ec}};
   endfunction

   task automatic chk(input string tag, input logic [6:0] exp);
      logic [6:0] obs;
      obs = {h, c, fault, busy};
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed h,c,fault,busy=%b expected=%b", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; en = 2'b00; fault_clr = 1'b0;
      tr0 = 7'd60; tr1 = 7'd60; rf0 = 7'd60; rf1 = 7'd60; dt = 7'd2;
      step();
      step();
      chk("reset_state", ev(2'b00, 2'b00, 2'b00));
      #3 reset = 1'b1;
      step();
      chk("post_reset_idle", ev(2'b00, 2'b00, 2'b00));

      // T1: heat entry, target reached early, held for the minimum on-time
      tr0 = 7'd15; rf0 = 7'd25; dt = 7'd2; start = 1'b1; en = 2'b01;
      step();
      chk("t1_heat_entry", ev(2'b01, 2'b00, 2'b00));
      tr0 = 7'd25;
      for (int k = 2; k <= 4; k++) begin
         step();
         chk($sformatf("t1_min_on_%0d", k), ev(2'b01, 2'b00, 2'b00));
      end
      step();
      chk("t1_release", ev(2'b00, 2'b00, 2'b00));
      step();
      chk("t1_idle", ev(2'b00, 2'b00, 2'b00));

      // T2: inside the deadband (lo=23, hi=27) nothing happens
      tr0 = 7'd24;
      for (int k = 0; k < 15; k++) begin
         step();
         chk($sformatf("t2_db24_%0d", k), ev(2'b00, 2'b00, 2'b00));
      end
      tr0 = 7'd27;
      for (int k = 0; k < 15; k++) begin
         step();
         chk($sformatf("t2_db27_%0d", k), ev(2'b00, 2'b00, 2'b00));
      end

      // T3: timeout into FAULT, latched until fault_clr
      tr0 = 7'd15;
      for (int k = 1; k <= 20; k++) begin
         step();
         chk($sformatf("t3_heat_%0d", k), ev(2'b01, 2'b00, 2'b00));
      end
      step();
      chk("t3_fault_entry", ev(2'b00, 2'b00, 2'b01));
      en = 2'b00;
      for (int k = 0; k < 5; k++) begin
         step();
         chk($sformatf("t3_fault_hold_%0d", k), ev(2'b00, 2'b00, 2'b01));
      end
      en = 2'b01;
      step();
      chk("t3_fault_en_ignored", ev(2'b00, 2'b00, 2'b01));
      fault_clr = 1'b1;
      step();
      fault_clr = 1'b0;
      chk("t3_fault_clr", ev(2'b00, 2'b00, 2'b00));
      step();
      chk("t3_reheat", ev(2'b01, 2'b00, 2'b00));
      en = 2'b00;
      step();
      chk("t3_en_cut", ev(2'b00, 2'b00, 2'b00));

      // T4: boundaries
      en = 2'b01; rf0 = 7'd1; dt = 7'd3; tr0 = 7'd0;
      for (int k = 0; k < 5; k++) begin
         step();
         chk($sformatf("t4_lo_sat_%0d", k), ev(2'b00, 2'b00, 2'b00));
      end
      rf0 = 7'd120; dt = 7'd10; tr0 = 7'd127;
      for (int k = 0; k < 5; k++) begin
         step();
         chk($sformatf("t4_hi_nowrap_%0d", k), ev(2'b00, 2'b00, 2'b00));
      end
      rf0 = 7'd25; dt = 7'd2; tr0 = 7'd15;
      for (int k = 1; k <= 20; k++) begin
         step();
         chk($sformatf("t4_to_heat_%0d", k), ev(2'b01, 2'b00, 2'b00));
      end
      tr0 = 7'd25;
      step();
      chk("t4_target_on_timeout", ev(2'b00, 2'b00, 2'b00));
      step();
      chk("t4_no_fault_after", ev(2'b00, 2'b00, 2'b00));

      // T5: concurrent heat (z0) and cool (z1), z1 enable dropped early
      tr0 = 7'd15; rf0 = 7'd25; tr1 = 7'd90; rf1 = 7'd60; dt = 7'd5; en = 2'b11;
      step();
      chk("t5_both_on", ev(2'b01, 2'b10, 2'b00));
      step();
      chk("t5_cycle2", ev(2'b01, 2'b10, 2'b00));
      en = 2'b01;
      step();
      chk("t5_cool_cut", ev(2'b01, 2'b00, 2'b00));
      en = 2'b00;
      step();
      chk("t5_heat_cut", ev(2'b00, 2'b00, 2'b00));

      // T6: asynchronous reset mid-HEAT, then re-entry
      tr1 = 7'd60; rf1 = 7'd60; dt = 7'd2; en = 2'b01;
      step();
      chk("t6_heat", ev(2'b01, 2'b00, 2'b00));
      #2 reset = 1'b0;
      #1;
      chk("t6_async_drop", ev(2'b00, 2'b00, 2'b00));
      step();
      chk("t6_held_in_reset", ev(2'b00, 2'b00, 2'b00));
      #2 reset = 1'b1;
      step();
      chk("t6_reentry", ev(2'b01, 2'b00, 2'b00));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
